pic_core_clocked: RTL
=====================

Name: pic_core_clocked

Overview:
- Clocked, parametrised successor of the 8259-style interrupt controller; replaces the unclocked IRR/priority/control split with one synchronous block.
- Provides N_IRQ request channels, a programmable mask, per-channel edge/level trigger, fixed or rotating priority, auto-EOI option and a registered vector handshake on INTA.
- Sits between peripheral IR lines and the CPU bus. IR inputs are already synchronous to CLK.

Parameters:
- N_IRQ, 8, number of request channels (2..DATA_W).
- DATA_W, 8, register/data bus width; VEC has the same width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IR  in  N_IRQ  interrupt request lines; bit 0 = channel 0.
- CS  in  1  chip select, active-high.
- WR  in  1  write strobe, active-high, sampled with CS.
- RD  in  1  read strobe, active-high, sampled with CS.
- A  in  3  register address.
- DIN  in  DATA_W  write data.
- DOUT  out  DATA_W  registered read data.
- INT  out  1  registered interrupt request to CPU.
- INTA  in  1  acknowledge, active-high level from CPU.
- VEC  out  DATA_W  vector = VBASE + channel id, registered.
- VEC_VALID  out  1  VEC holds an acknowledged vector.

Behaviour:
- Reset values: IMR all 1 (masked), TRIG all 1 (edge), CTRL 0, VBASE 0, IRR 0, ISR 0, PRI_PTR 0, FSM IDLE, DOUT 0, INT 0, VEC 0, VEC_VALID 0. The edge-history register loads IR during reset, so a line already high at reset release does not produce an edge.
- Registers:
  - A=0 IMR, rw.
  - A=1 TRIG, rw; 1 = edge, 0 = level.
  - A=2 CTRL, rw; bit0 ROT, bit1 AEOI.
  - A=3 VBASE, rw.
  - A=4 EOI, write-only; any data = non-specific EOI.
  - A=4 read returns IRR; A=5 read returns ISR.
  - Bits above N_IRQ read 0. Undefined addresses read 0 and ignore writes.
- Write takes effect on the edge where CS&WR&!RD. Read loads DOUT on the edge where CS&RD&!WR, so data is visible 1 cycle later. CS&WR&RD is ignored.
- IRR, edge channels: set on a 0->1 transition of IR; cleared only when the channel is acknowledged.
- IRR, level channels: IRR bit follows IR every cycle. An edge->level TRIG change makes the bit follow IR on the next cycle.
- Masking: IRR latches regardless of IMR. IMR only removes a channel from selection.
- Priority order starts at PRI_PTR (highest) and wraps modulo N_IRQ. With ROT=0, PRI_PTR is held at 0.
- Winner = highest-priority bit of IRR & ~IMR that ranks above the highest-priority ISR bit; no ISR bit means any candidate qualifies.
- INT <= (winner exists) registered, so it follows IRR/IMR/ISR changes by 1 cycle. INT is forced 0 while the FSM is in ACK.
- FSM states:
  - IDLE: on INTA rising (INTA=1 with previous INTA=0), go to ACK. If a winner k exists: set ISR[k] (unless AEOI), clear IRR[k] if edge, VEC <= VBASE+k. If no winner (spurious): VEC <= VBASE+N_IRQ-1, no ISR/IRR change. Either way VEC_VALID <= 1.
  - ACK: hold VEC. When INTA=0, go to IDLE and VEC_VALID <= 0.
- EOI clears the highest-priority set ISR bit; with ISR=0 it has no effect.
- Rotation: with ROT=1, PRI_PTR <= (k+1) mod N_IRQ when channel k's ISR bit is cleared by EOI. With AEOI=1, the update happens at acknowledge instead.
- Vector arithmetic: VBASE+k is taken modulo 2^DATA_W; wrap is permitted.
- Simultaneous events: the winner is evaluated on pre-edge state. EOI clears on pre-edge ISR and the acknowledge set is applied after, so the set wins on the same bit. An IMR write and an acknowledge in the same cycle use the old IMR. An edge and an acknowledge on the same channel in the same cycle leave IRR set.
- RESET asserted mid-acknowledge: FSM returns to IDLE and all state takes reset values on that edge, regardless of INTA.

Test Plan:
- Reset, IMR=0x00, VBASE=0x20, pulse IR[3] -> INT=1 after 2 cycles; INTA high -> VEC=0x23, VEC_VALID=1, ISR=0x08, IRR=0x00; INTA low -> VEC_VALID=0.
- IR[5] and IR[2] rise together, fixed priority -> first ack VEC=VBASE+2. IR[5] stays pending with INT=0 until EOI. After EOI, INT=1 and second ack VEC=VBASE+5.
- ROT=1, IR[0] and IR[1] held pending repeatedly (level): ack+EOI for channel 0 -> PRI_PTR=1, next ack gives channel 1, then PRI_PTR=2.
- IMR=0xFF, IR toggles -> IRR latches, INT=0. INTA pulse -> spurious VEC=VBASE+7, ISR unchanged.
- AEOI=1, level IR[4] held high -> ack gives VEC=VBASE+4 with ISR=0, and INT re-asserts 1 cycle after INTA falls.
- RESET asserted during ACK with VEC_VALID=1 -> next cycle VEC_VALID=0, INT=0, IMR=all 1, ISR=0.

Source files
------------

// File: rtl/pic_core_clocked_if.sv
// Bus bundle for pic_core_clocked: IR lines, register port and INTA/vector
// handshake.
interface pic_core_clocked_if #(
  parameter int N_IRQ  = 8,
  parameter int DATA_W = 8
);
  logic [N_IRQ-1:0]  IR;
  logic              CS;
  logic              WR;
  logic              RD;
  logic [2:0]        A;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;
  logic              INT;
  logic              INTA;
  logic [DATA_W-1:0] VEC;
  logic              VEC_VALID;

  modport master (
    output IR, CS, WR, RD, A, DIN, INTA,
    input  DOUT, INT, VEC, VEC_VALID
  );

  modport slave (
    input  IR, CS, WR, RD, A, DIN, INTA,
    output DOUT, INT, VEC, VEC_VALID
  );
endinterface

// File: rtl/pic_core_clocked.sv
// Synchronous 8259-style interrupt controller: IRR/ISR, mask, edge/level,
// fixed or rotating priority, auto-EOI and registered INTA vector.
module pic_core_clocked #(
  parameter int N_IRQ  = 8,
  parameter int DATA_W = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  pic_core_clocked_if.slave bus
);

  localparam int PW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {IDLE, ACK} state_t;

  logic [N_IRQ-1:0]  imr_q, imr_d;
  logic [N_IRQ-1:0]  trig_q, trig_d;
  logic [N_IRQ-1:0]  irr_q, irr_d;
  logic [N_IRQ-1:0]  isr_q, isr_d;
  logic [N_IRQ-1:0]  ir_prev_q;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] vbase_q, vbase_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] vec_q, vec_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  state_t            state_q, state_d;
  logic              int_q, int_d;
  logic              vv_q, vv_d;
  logic              inta_prev_q;

  logic [N_IRQ-1:0]  cand;
  logic              c_hit, s_hit, win;
  logic [PW-1:0]     c_idx, c_rank;
  logic [PW-1:0]     s_idx, s_rank;
  int                idx;

  logic              wr_en, rd_en;
  logic              ack_ev, ack_hit, eoi;
  logic [N_IRQ-1:0]  rise, ack_oh, eoi_oh;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] k);
    return (int'(k) == N_IRQ - 1) ? '0 : k + PW'(1);
  endfunction

  // Ranks count from ptr_q; lower rank = higher priority.
  always_comb begin
    cand   = irr_q & ~imr_q;
    c_hit  = 1'b0;
    s_hit  = 1'b0;
    c_idx  = '0;
    c_rank = '0;
    s_idx  = '0;
    s_rank = '0;
    idx    = 0;
    for (int i = 0; i < N_IRQ; i++) begin
      idx = (int'(ptr_q) + i) % N_IRQ;
      if (!c_hit && cand[idx]) begin
        c_hit  = 1'b1;
        c_idx  = PW'(idx);
        c_rank = PW'(i);
      end
      if (!s_hit && isr_q[idx]) begin
        s_hit  = 1'b1;
        s_idx  = PW'(idx);
        s_rank = PW'(i);
      end
    end
    win = c_hit && (!s_hit || (c_rank < s_rank));
  end

  always_comb begin
    imr_d   = imr_q;
    trig_d  = trig_q;
    ctrl_d  = ctrl_q;
    vbase_d = vbase_q;
    dout_d  = dout_q;
    vec_d   = vec_q;
    vv_d    = vv_q;
    state_d = state_q;
    ptr_d   = ptr_q;

    wr_en   = bus.CS & bus.WR & ~bus.RD;
    rd_en   = bus.CS & bus.RD & ~bus.WR;
    rise    = bus.IR & ~ir_prev_q;
    ack_ev  = (state_q == IDLE) && bus.INTA && !inta_prev_q;
    ack_hit = ack_ev && win;
    eoi     = wr_en && (bus.A == 3'd4) && s_hit;
    ack_oh  = ack_hit ? (N_IRQ'(1) << c_idx) : '0;
    eoi_oh  = eoi ? (N_IRQ'(1) << s_idx) : '0;

    if (wr_en) begin
      case (bus.A)
        3'd0:    imr_d   = bus.DIN[N_IRQ-1:0];
        3'd1:    trig_d  = bus.DIN[N_IRQ-1:0];
        3'd2:    ctrl_d  = bus.DIN[1:0];
        3'd3:    vbase_d = bus.DIN;
        default: ;
      endcase
    end

    if (rd_en) begin
      case (bus.A)
        3'd0:    dout_d = DATA_W'(imr_q);
        3'd1:    dout_d = DATA_W'(trig_q);
        3'd2:    dout_d = DATA_W'(ctrl_q);
        3'd3:    dout_d = vbase_q;
        3'd4:    dout_d = DATA_W'(irr_q);
        3'd5:    dout_d = DATA_W'(isr_q);
        default: dout_d = '0;
      endcase
    end

    // An edge arriving with its own acknowledge keeps the request pending.
    irr_d = (trig_q & ((irr_q & ~ack_oh) | rise))
          | (~trig_q & bus.IR);
    isr_d = (isr_q & ~eoi_oh) | (ctrl_q[1] ? '0 : ack_oh);

    if (!ctrl_q[0])
      ptr_d = '0;
    else if (ack_hit && ctrl_q[1])
      ptr_d = nxt(c_idx);
    else if (eoi && !ctrl_q[1])
      ptr_d = nxt(s_idx);

    unique case (state_q)
      IDLE: begin
        if (ack_ev) begin
          state_d = ACK;
          vv_d    = 1'b1;
          vec_d   = win ? vbase_q + DATA_W'(c_idx)
                        : vbase_q + DATA_W'(N_IRQ - 1);
        end
      end
      ACK: begin
        if (!bus.INTA) begin
          state_d = IDLE;
          vv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    int_d = win && (state_d == IDLE);
  end

  // History registers track inputs through reset so held lines are not edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      imr_q       <= '1;
      trig_q      <= '1;
      ctrl_q      <= '0;
      vbase_q     <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      ptr_q       <= '0;
      state_q     <= IDLE;
      dout_q      <= '0;
      int_q       <= 1'b0;
      vec_q       <= '0;
      vv_q        <= 1'b0;
      ir_prev_q   <= bus.IR;
      inta_prev_q <= bus.INTA;
    end else begin
      imr_q       <= imr_d;
      trig_q      <= trig_d;
      ctrl_q      <= ctrl_d;
      vbase_q     <= vbase_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      dout_q      <= dout_d;
      int_q       <= int_d;
      vec_q       <= vec_d;
      vv_q        <= vv_d;
      ir_prev_q   <= bus.IR;
      inta_prev_q <= bus.INTA;
    end
  end

  assign bus.DOUT      = dout_q;
  assign bus.INT       = int_q;
  assign bus.VEC       = vec_q;
  assign bus.VEC_VALID = vv_q;

endmodule
